// File: rtl/fmrom_spi_reader.sv
// rtl/fmrom_spi_reader.sv - FM-PAC ROM window reader: fetches one byte per Z80 read from SPI flash
// Holds the Z80 in WAIT while the byte is fetched, then drives it until the read ends.
module fmrom_spi_reader #(
   parameter logic [23:0] ROM_BASE = 24'h100000,
   parameter logic [1:0]  WIN_HI   = 2'b01
) (
   input  logic        ex_clk_27m,
   input  logic        reset,
   input  logic        bus_sltsl_n,
   input  logic        busMreq_n,
   input  logic        bus_rd_n,
   input  logic [15:0] bus_addr,
   output logic [7:0]  bus_data_out,
   output logic        bus_data_reverse,
   output logic        bus_wait_n,
   output logic        spi_cs_n,
   output logic        spi_sck,
   output logic        spi_mosi,
   input  logic        spi_miso,
   output logic        fmrom_read,
   output logic [1:0]  fmrom_state,
   output logic [4:0]  fmrom_counter
);

   typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, DATA = 2'd2, HOLD = 2'd3} state_t;

   state_t      state_q, state_d;
   logic [1:0]  sltsl_q, mreq_q, rd_q;
   logic        q_prev_q;
   logic [31:0] shift_q, shift_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        phase_q, phase_d;
   logic [7:0]  rx_q, rx_d;
   logic [7:0]  dout_q, dout_d;
   logic        q, trig, active;

   assign q    = !sltsl_q[1] && !mreq_q[1] && !rd_q[1] && (bus_addr[15:14] == WIN_HI);
   assign trig = q && !q_prev_q;

   // History resets as "already high" so an access held across reset cannot fire.
   always_ff @(posedge ex_clk_27m) begin
      if (reset) begin
         sltsl_q  <= 2'b00;
         mreq_q   <= 2'b00;
         rd_q     <= 2'b00;
         q_prev_q <= 1'b1;
      end else begin
         sltsl_q  <= {sltsl_q[0], bus_sltsl_n};
         mreq_q   <= {mreq_q[0], busMreq_n};
         rd_q     <= {rd_q[0], bus_rd_n};
         q_prev_q <= q;
      end
   end

   always_ff @(posedge ex_clk_27m) begin
      if (reset) begin
         state_q <= IDLE;
         shift_q <= 32'd0;
         cnt_q   <= 5'd0;
         phase_q <= 1'b0;
         rx_q    <= 8'd0;
         dout_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
         rx_q    <= rx_d;
         dout_q  <= dout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      phase_d = phase_q;
      rx_d    = rx_q;
      dout_d  = dout_q;
      case (state_q)
         IDLE: begin
            if (trig) begin
               state_d = CMD;
               shift_d = {8'h03, ROM_BASE + {10'd0, bus_addr[13:0]}};
               cnt_d   = 5'd31;
               phase_d = 1'b0;
            end
         end
         CMD: begin
            if (!q) begin
               state_d = IDLE;
               cnt_d   = 5'd0;
               phase_d = 1'b0;
            end else if (!phase_q) begin
               phase_d = 1'b1;
            end else begin
               phase_d = 1'b0;
               shift_d = {shift_q[30:0], 1'b0};
               if (cnt_q == 5'd0) begin
                  state_d = DATA;
                  cnt_d   = 5'd7;
               end else begin
                  cnt_d = cnt_q - 5'd1;
               end
            end
         end
         DATA: begin
            if (!q) begin
               state_d = IDLE;
               cnt_d   = 5'd0;
               phase_d = 1'b0;
            end else if (!phase_q) begin
               phase_d = 1'b1;
            end else begin
               // miso is taken while sck is high, at the end of the high half.
               phase_d = 1'b0;
               rx_d    = {rx_q[6:0], spi_miso};
               if (cnt_q == 5'd0) begin
                  state_d = HOLD;
                  dout_d  = {rx_q[6:0], spi_miso};
               end else begin
                  cnt_d = cnt_q - 5'd1;
               end
            end
         end
         HOLD: begin
            if (!q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign active           = (state_q == CMD) || (state_q == DATA);
   assign spi_cs_n         = !active;
   assign spi_sck          = active && phase_q;
   assign spi_mosi         = (state_q == CMD) && shift_q[31];
   assign bus_wait_n       = !active;
   assign bus_data_reverse = (state_q == HOLD) && q;
   assign fmrom_read       = active || bus_data_reverse;
   assign bus_data_out     = dout_q;
   assign fmrom_state      = state_q;
   assign fmrom_counter    = cnt_q;

endmodule
